// File: rtl/reg_burst_loader_if.sv
// reg_burst_loader_if: sequencer-side write bus, read port and status outputs of the burst loader
//   regnum       register number to write this cycle (0 = no write)
//   seq_done     sequencer done level
//   base         data base value for the burst
//   rd_num       read-port register select
//   rd_data      contents of the selected register (0 for register 0)
//   busy         loader is accepting burst writes
//   loaded       one-cycle burst completion pulse
//   wcount       writes in the current or last burst (saturating)
//   written_mask registers touched in the current or last burst
//   dup_err      some register was written twice in the current or last burst
interface reg_burst_loader_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 4
);
   logic [4:0]       regnum;
   logic             seq_done;
   logic [WIDTH-1:0] base;
   logic [4:0]       rd_num;
   logic [WIDTH-1:0] rd_data;
   logic             busy;
   logic             loaded;
   logic [CNT_W-1:0] wcount;
   logic [31:0]      written_mask;
   logic             dup_err;
   modport master (
      output regnum, seq_done, base, rd_num,
      input  rd_data, busy, loaded, wcount, written_mask, dup_err
   );
   modport slave (
      input  regnum, seq_done, base, rd_num,
      output rd_data, busy, loaded, wcount, written_mask, dup_err
   );
endinterface

// File: rtl/reg_burst_loader.sv
// reg_burst_loader: writes base+k into a 32-entry register file for each register number of a sequencer burst
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    reg_burst_loader_if slave: burst input, combinational read port and burst status
module reg_burst_loader #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 4
) (
   input logic clock,
   input logic reset,
   reg_burst_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, HOLD} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] regs [32];
   logic [CNT_W-1:0] wcount;
   logic [31:0]      mask;
   logic             dup, loaded;
   logic             start, wr_load;
   logic [WIDTH-1:0] wdata;
   always_comb begin
      // a new burst may start from IDLE or directly out of HOLD once done drops
      start    = bus.regnum != '0 && (state == IDLE || (state == HOLD && !bus.seq_done));
      wr_load  = bus.regnum != '0 && state == LOAD && !bus.seq_done;
      // offset is the pre-increment count; since the count saturates, so does the offset
      wdata    = bus.base + (start ? {WIDTH{1'b0}} : WIDTH'(wcount));
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (bus.seq_done) state_nx = COMMIT;
         COMMIT:  state_nx = HOLD;
         HOLD:    if (start) state_nx = LOAD;
                  else if (!bus.seq_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         wcount <= '0;
         mask   <= '0;
         dup    <= 1'b0;
         loaded <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         state  <= state_nx;
         loaded <= state_nx == COMMIT;
         if (start || wr_load) regs[bus.regnum] <= wdata;
         if (start) begin
            wcount <= CNT_W'(1);
            mask   <= 32'd1 << bus.regnum;
            dup    <= 1'b0;
         end else if (wr_load) begin
            wcount <= &wcount ? wcount : wcount + 1'b1;
            mask   <= mask | (32'd1 << bus.regnum);
            dup    <= dup | mask[bus.regnum];
         end
      end
   end
   // register 0 is never written, but the read port forces it to zero regardless
   assign bus.rd_data      = bus.rd_num == '0 ? '0 : regs[bus.rd_num];
   assign bus.busy         = state == LOAD;
   assign bus.loaded       = loaded;
   assign bus.wcount       = wcount;
   assign bus.written_mask = mask;
   assign bus.dup_err      = dup;
endmodule

// File: tb/tb_reg_burst_loader.sv
// tb_reg_burst_loader: randomized and directed bursts checked against a register-file model and a burst-summary scoreboard
module tb_reg_burst_loader;
   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   logic clock = 1'b0;
   logic reset = 1'b1;
   reg_burst_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
   reg_burst_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );
   always #5 clock = ~clock;
   typedef struct {
      logic [CNT_W-1:0] wc;
      logic [31:0]      mask;
      logic             dup;
   } exp_t;
   exp_t             exp_q[$];
   exp_t             got;
   logic [WIDTH-1:0] mdl [32];
   logic [CNT_W-1:0] m_wc;
   logic [31:0]      m_mask;
   logic             m_dup;
   bit               open;
   int               k;
   int               checks = 0, failures = 0, pulses = 0, bursts = 0;
   logic [4:0]       stim[$];
   logic             prev_loaded = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask
   // scoreboard monitor: every completion pulse must match the oldest finished burst
   always @(negedge clock) begin
      if (reset && bus.loaded) begin
         pulses++;
         chk("loaded_single_cycle", {31'd0, prev_loaded}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_loaded actual=1 expected=0 at %0t", $time);
         end else begin
            got = exp_q.pop_front();
            chk("sb_wcount", {28'd0, bus.wcount}, {28'd0, got.wc});
            chk("sb_mask", bus.written_mask, got.mask);
            chk("sb_dup", {31'd0, bus.dup_err}, {31'd0, got.dup});
         end
      end
      prev_loaded = bus.loaded;
   end
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic clear_model();
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      m_wc = '0;
      m_mask = '0;
      m_dup = 1'b0;
      open = 1'b0;
      k = 0;
   endtask
   task automatic feed(input logic [WIDTH-1:0] b);
      foreach (stim[i]) begin
         logic [4:0] r;
         r = stim[i];
         bus.regnum = r;
         bus.rd_num = r;
         bus.base = b;
         bus.seq_done = 1'b0;
         #3 chk("rd_before_write", bus.rd_data, mdl[r]);
         if (r != 0) begin
            if (!open) begin
               open = 1'b1;
               k = 0;
               m_mask = '0;
               m_dup = 1'b0;
            end else if (m_mask[r]) m_dup = 1'b1;
            mdl[r] = b + WIDTH'(k > CMAX ? CMAX : k);
            m_mask[r] = 1'b1;
            k++;
            m_wc = CNT_W'(k > CMAX ? CMAX : k);
         end
         step();
         chk("rd_after_write", bus.rd_data, mdl[r]);
         if (open) chk("busy_in_load", {31'd0, bus.busy}, 32'd1);
      end
   endtask
   task automatic done_phase(input int hold);
      exp_t e;
      bus.seq_done = 1'b1;
      bus.regnum = open ? 5'($urandom_range(1, 31)) : 5'd0;
      bus.rd_num = 5'd0;
      if (open) begin
         e.wc = m_wc;
         e.mask = m_mask;
         e.dup = m_dup;
         exp_q.push_back(e);
         bursts++;
         open = 1'b0;
      end
      repeat (hold) step();
      chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
   endtask
   task automatic idle(input int n);
      bus.seq_done = 1'b0;
      bus.regnum = 5'd0;
      bus.rd_num = 5'd0;
      repeat (n) step();
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_wcount", {28'd0, bus.wcount}, {28'd0, m_wc});
      chk("idle_mask", bus.written_mask, m_mask);
      chk("idle_dup", {31'd0, bus.dup_err}, {31'd0, m_dup});
      chk("idle_rd0", bus.rd_data, 32'd0);
   endtask
   task automatic sweep();
      bus.regnum = 5'd0;
      for (int i = 0; i < 32; i++) begin
         bus.rd_num = 5'(i);
         #1 chk("sweep_reg", bus.rd_data, mdl[i]);
      end
      step();
   endtask
   task automatic chk_reg(input logic [4:0] n, input logic [WIDTH-1:0] v);
      bus.rd_num = n;
      #1 chk("reg_value", bus.rd_data, v);
   endtask
   initial begin
      bus.regnum = 5'd0;
      bus.seq_done = 1'b0;
      bus.base = '0;
      bus.rd_num = 5'd0;
      clear_model();
      #1 reset = 1'b0;
      #2;
      chk("reset_wcount", {28'd0, bus.wcount}, 32'd0);
      chk("reset_mask", bus.written_mask, 32'd0);
      chk("reset_dup", {31'd0, bus.dup_err}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_loaded", {31'd0, bus.loaded}, 32'd0);
      #4 reset = 1'b1;
      step();
      idle(2);
      // up burst
      stim = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
      feed(32'h100);
      done_phase(1);
      chk_reg(5'd8, 32'h100);
      chk_reg(5'd12, 32'h104);
      chk("up_wcount", {28'd0, bus.wcount}, 32'd5);
      chk("up_mask", bus.written_mask, 32'h0000_1F00);
      idle(2);
      // down burst wrapping through zero
      stim = '{5'd8, 5'd7, 5'd6, 5'd5, 5'd4};
      feed(32'hFFFF_FFFE);
      done_phase(2);
      chk_reg(5'd7, 32'hFFFF_FFFF);
      chk_reg(5'd6, 32'h0);
      chk_reg(5'd4, 32'h2);
      chk("down_mask", bus.written_mask, 32'h0000_01F0);
      idle(1);
      // duplicate with a gap, then back-to-back burst straight out of HOLD
      stim = '{5'd8, 5'd0, 5'd9, 5'd8};
      feed(32'h10);
      done_phase(3);
      chk_reg(5'd8, 32'h12);
      chk_reg(5'd9, 32'h11);
      chk("dup_wcount", {28'd0, bus.wcount}, 32'd3);
      chk("dup_flag", {31'd0, bus.dup_err}, 32'd1);
      chk("dup_mask", bus.written_mask, 32'h0000_0300);
      stim = '{5'd8};
      feed(32'h200);
      chk_reg(5'd8, 32'h200);
      chk("b2b_mask", bus.written_mask, 32'h0000_0100);
      chk("b2b_dup", {31'd0, bus.dup_err}, 32'd0);
      done_phase(2);
      idle(1);
      // asynchronous reset in the middle of a burst
      stim = '{5'd8, 5'd9, 5'd10};
      feed(32'h300);
      #2 reset = 1'b0;
      bus.regnum = 5'd0;
      clear_model();
      #1;
      chk("mid_reset_wcount", {28'd0, bus.wcount}, 32'd0);
      chk("mid_reset_mask", bus.written_mask, 32'd0);
      chk("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
      chk_reg(5'd8, 32'h0);
      chk_reg(5'd9, 32'h0);
      #2 reset = 1'b1;
      step();
      idle(1);
      stim = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
      feed(32'h100);
      done_phase(2);
      chk("post_reset_wcount", {28'd0, bus.wcount}, 32'd5);
      sweep();
      // randomized bursts, some longer than the counter range
      for (int t = 0; t < 40; t++) begin
         int n;
         n = $urandom_range(1, 20);
         stim = {};
         stim.push_back(5'($urandom_range(1, 31)));
         for (int j = 1; j < n; j++)
            stim.push_back($urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31)));
         feed($urandom);
         done_phase($urandom_range(2, 4));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
         if (t % 10 == 9) sweep();
      end
      done_phase(2);
      idle(2);
      sweep();
      repeat (3) step();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      chk("loaded_pulse_count", pulses, bursts);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_burst_loader.md
Name: reg_burst_loader

Overview:
Downstream consumer of the register-number sequencer's burst output. Each cycle the sequencer presents a nonzero register number, this block writes a generated data word into a 32-entry register file. It tracks which registers a burst touched, counts writes, flags duplicate writes, and pulses a completion strobe when the sequencer signals done. The register file has one combinational read port for the datapath and the bench.

Parameters:
WIDTH, 32, register data width in bits
CNT_W, 4, width of the per-burst write counter (saturating)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
regnum  in  5  register number from sequencer; 0 = no write this cycle
seq_done  in  1  sequencer done level; high from end of burst until the next go
base  in  WIDTH  data base value; the k-th write of a burst stores base+k
rd_num  in  5  read-port register select
rd_data  out  WIDTH  contents of reg[rd_num]; always 0 when rd_num=0
busy  out  1  high while in LOAD
loaded  out  1  one-cycle pulse when a burst completes
wcount  out  CNT_W  writes performed in the current or last burst
written_mask  out  32  bit i set if reg i was written in the current or last burst
dup_err  out  1  high if any register was written twice in the current or last burst

Behaviour:
- Reset (reset=0, async): all 32 registers=0, state=IDLE, wcount=0, written_mask=0, dup_err=0, loaded=0, busy=0. Reset mid-burst aborts the burst immediately with no partial commit. No loaded pulse occurs.
- Register 0 is hardwired 0. Writes with regnum=0 never occur.
- States: IDLE, LOAD, COMMIT, HOLD. All writes, counters and flags update on the rising clock edge.
- Burst start (IDLE, or HOLD with seq_done=0), when regnum!=0:
  - write reg[regnum]=base+0
  - clear the old mask, then set written_mask to only bit regnum
  - wcount=1, dup_err=0
  - next state LOAD
- IDLE with regnum=0: stay in IDLE, no change.
- LOAD, seq_done=0, regnum!=0:
  - write reg[regnum]=base+wcount, using the pre-increment value zero-extended to WIDTH
  - wcount increments and saturates at 2^CNT_W-1; the data offset also saturates
  - if bit regnum is already set, dup_err=1; the write still occurs, last write wins
  - set bit regnum
- LOAD, seq_done=0, regnum=0: stay in LOAD, no write (idle gap).
- LOAD, seq_done=1: go to COMMIT. No write, even if regnum!=0 (seq_done has priority).
- COMMIT: loaded=1 for exactly this cycle. Next state HOLD. wcount, written_mask and dup_err are frozen.
- HOLD, seq_done=1: stay in HOLD.
- HOLD, seq_done=0, regnum=0: go to IDLE.
- HOLD, seq_done=0, regnum!=0: treat as burst start in the same cycle. This covers the sequencer dropping done and presenting register 8 on the same edge.
- Outputs:
  - loaded is registered (decoded from COMMIT state)
  - busy = (state==LOAD)
  - wcount, written_mask and dup_err hold their values until the next burst start
- Arithmetic: base+offset is computed modulo 2^WIDTH; carry-out is dropped.
- Read port: rd_data=reg[rd_num] combinationally. A read of the register being written in the same cycle returns the old value; the new value appears after the edge.
- Latency: a write is visible on rd_data one cycle after regnum is presented. loaded rises one cycle after seq_done is first sampled high in LOAD.

Test Plan:
- Up burst: base=0x100, regnum 8,9,10,11,12 on consecutive cycles, then seq_done=1 → reg8..reg12=0x100..0x104; wcount=5; written_mask=0x00001F00; dup_err=0; loaded high for exactly 1 cycle; busy low afterwards.
- Down burst with wrap: base=0xFFFFFFFE, regnum 8,7,6,5,4, then done → reg8=0xFFFFFFFE, reg7=0xFFFFFFFF, reg6=0, reg5=1, reg4=2; written_mask=0x000001F0.
- Duplicate with gap: base=0x10, regnum 8,0,9,8, then done → reg8=0x12, reg9=0x11; wcount=3; dup_err=1; written_mask=0x00000300.
- Back-to-back: after the first burst, hold seq_done=1 for 3 cycles, then drop it on the same edge regnum=8 appears, with base=0x200 → no IDLE cycle; reg8=0x200; mask cleared to 0x00000100; dup_err=0.
- Reset mid-burst: assert reset=0 asynchronously after 2 writes in LOAD → all registers, mask and wcount read 0 immediately. No loaded pulse. A subsequent burst behaves as in the up-burst case.
- Read-port and zero handling: rd_num=0 → rd_data=0 at all times. regnum=0 alone in IDLE → no state change. Read of reg9 during the cycle reg9 is written → old value, then new value the next cycle.
